clk_rst_sequencer: RTL and testbench
====================================

# clk_rst_sequencer

Reset sequencer for the MMCM-based clock manager. Drives the MMCM reset pulse, watches its `locked` status, releases the downstream reset only after lock has been stable for a programmable hold time, and restarts the MMCM when lock is lost or never acquired. It runs on a free-running board clock that does not come from the MMCM, and sits between the board reset and every MMCM-clocked domain.

## Interface
- `MMCM_RST_CYCLES`, 16: cycles `mmcm_rst_o` stays high after `rst_i` deasserts or after a restart; must be at least 1.
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry; must be at least 1.
- `HOLD_CYCLES`, 256: consecutive synchronized-lock cycles required before release; must be at least 1.
- `SYNC_STAGES`, 2: flop stages on `locked_i`; must be at least 2.
- `clk_i` input, 1 bit: free-running reference clock.
- `rst_i` input, 1 bit: reset; synchronous, active-high.
- `locked_i` input, 1 bit: MMCM LOCKED; asynchronous to `clk_i`.
- `mmcm_rst_o` output, 1 bit: MMCM RST request, registered.
- `rst_o` output, 1 bit: downstream reset, active-high, registered.
- `ready_o` output, 1 bit: high in RUN only; always equal to the inverse of `rst_o`.
- `lock_lost_o` output, 1 bit: sticky flag, set when lock drops in RUN.
- `retry_cnt_o` output, 8 bits: number of lock-timeout retries, saturates at 255.

## Operation
- `locked_i` passes through `SYNC_STAGES` flops; the result is `lock_s`. Only `lock_s` is used.
- States and transitions:
  - MMCM_RST: `mmcm_rst_o`=1. The counter runs 0..`MMCM_RST_CYCLES`-1, then the FSM goes to WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: `mmcm_rst_o`=0. When `lock_s`=1, go to HOLD with the counter cleared. When the counter reaches `LOCK_TIMEOUT`-1 and `lock_s` is still 0, increment `retry_cnt_o` (saturating) and go to MMCM_RST.
  - HOLD: the counter increments while `lock_s`=1. If `lock_s`=0, go back to WAIT_LOCK with the counter cleared; this is not a retry. When the counter reaches `HOLD_CYCLES`-1, go to RUN.
  - RUN: `rst_o`=0 and `ready_o`=1. When `lock_s`=0, set `lock_lost_o` and go to MMCM_RST.
- `rst_o`=1 in every state except RUN.
- A single shared counter is sized `$clog2` of the largest of the three cycle parameters, plus 1 bit.
- If a timeout and `lock_s` rising happen on the same cycle, lock wins and the FSM goes to HOLD.
- `lock_lost_o` and `retry_cnt_o` are cleared only by `rst_i`.

## Timing
- Reset: while `rst_i`=1, all of the following hold on the next edge:
  - state = MMCM_RST, counter = 0;
  - `mmcm_rst_o`=1, `rst_o`=1, `ready_o`=0, `lock_lost_o`=0, `retry_cnt_o`=0;
  - sync flops = 0.
- `rst_i` asserted mid-operation, including in RUN, restarts the full sequence on the next edge.
- `mmcm_rst_o` is high for exactly `MMCM_RST_CYCLES` cycles after `rst_i` falls, then goes low.
- Release latency: a `locked_i` rising edge seen at edge N (in WAIT_LOCK) makes `rst_o` fall at edge N+`SYNC_STAGES`+`HOLD_CYCLES`+1, provided lock stays high throughout.
- Lock-loss latency: a `locked_i` fall seen at edge N in RUN makes `rst_o` and `mmcm_rst_o` rise and `lock_lost_o` set at edge N+`SYNC_STAGES`+1.
- Timeout: with no lock, `mmcm_rst_o` rises again `LOCK_TIMEOUT` cycles after it fell. `retry_cnt_o` updates in that same cycle.
- All outputs are glitch-free registers.

## Configuration
- `CLK_RST_SEQ_RETRY_EN` defined:
  - the WAIT_LOCK timeout and retry path are as described above.
- `CLK_RST_SEQ_RETRY_EN` undefined:
  - WAIT_LOCK waits indefinitely for `lock_s`;
  - `retry_cnt_o` is tied to 0;
  - `LOCK_TIMEOUT` is ignored;
  - all other behaviour is identical.

## Test plan
All scenarios use `MMCM_RST_CYCLES`=4, `LOCK_TIMEOUT`=100, `HOLD_CYCLES`=8, `SYNC_STAGES`=2.
- Power-up: hold `rst_i` for 3 cycles, then release; raise `locked_i` 10 cycles after release. Expect `mmcm_rst_o` high for 4 cycles after release, `rst_o` falling 11 cycles after `locked_i` rises, and `ready_o`=1.
- Glitchy lock: `locked_i` high for 5 cycles, low for 1 cycle, then high. Expect the FSM back in WAIT_LOCK, `retry_cnt_o`=0, and release 11 cycles after the final rise.
- Timeout (macro defined): keep `locked_i`=0. Expect `mmcm_rst_o` to re-pulse for 4 cycles every 104 cycles, and `retry_cnt_o`=3 after 3 timeouts. Forcing 300 timeouts gives `retry_cnt_o`=255.
- Lock loss in RUN: drop `locked_i`. Expect `rst_o`=1, `mmcm_rst_o`=1 and `lock_lost_o`=1 three cycles later; relock gives release again with `lock_lost_o` still 1.
- Mid-sequence reset: assert `rst_i` in HOLD and in RUN. Expect all outputs at reset values on the next edge and `lock_lost_o`=0.
- Macro undefined: `locked_i`=0 for 1000 cycles. Expect `mmcm_rst_o` to pulse only once, `retry_cnt_o`=0, and normal release after a late lock.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a stable synchronized lock,
// then releases the downstream reset. Optional lock-timeout retry via CLK_RST_SEQ_RETRY_EN.
module clk_rst_sequencer #(
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int HOLD_CYCLES     = 256,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  output logic       mmcm_rst_o,
  output logic       rst_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_MMCM_RST = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  localparam int MAX_A   = (MMCM_RST_CYCLES > HOLD_CYCLES) ? MMCM_RST_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef CLK_RST_SEQ_RETRY_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lock_drop;
  logic                   lost_pend_q;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign ready_o = ~rst_o;
  assign state_o = state_q;

`ifdef CLK_RST_SEQ_RETRY_EN
  logic timeout_hit;
  logic retry_pend_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lock_drop = 1'b0;
`ifdef CLK_RST_SEQ_RETRY_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_MMCM_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // Lock is checked first so a simultaneous timeout loses to it.
        if (lock_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
`ifdef CLK_RST_SEQ_RETRY_EN
        else if (cnt_q == TO_LAST) begin
          state_d     = ST_MMCM_RST;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d   = ST_MMCM_RST;
          cnt_d     = '0;
          lock_drop = 1'b1;
        end
      end
      default: begin
        state_d = ST_MMCM_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the registered state one cycle later, so every
  // output (including the sticky flags) moves on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_MMCM_RST;
      cnt_q       <= '0;
      sync_q      <= '0;
      mmcm_rst_o  <= 1'b1;
      rst_o       <= 1'b1;
      lost_pend_q <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], locked_i};
      mmcm_rst_o  <= (state_q == ST_MMCM_RST);
      rst_o       <= (state_q != ST_RUN);
      lost_pend_q <= lock_drop;
      if (lost_pend_q) begin
        lock_lost_o <= 1'b1;
      end
    end
  end

`ifdef CLK_RST_SEQ_RETRY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_pend_q <= 1'b0;
      retry_cnt_o  <= 8'd0;
    end else begin
      retry_pend_q <= timeout_hit;
      if (retry_pend_q && (retry_cnt_o != 8'hFF)) begin
        retry_cnt_o <= retry_cnt_o + 8'd1;
      end
    end
  end
`else
  assign retry_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: directed lock/unlock/reset sequences; every output
// change is matched against a queue of expected (cycle, value) events.
module tb_clk_rst_sequencer;

  logic       clk;
  logic       rst_i;
  logic       locked_i;
  logic       mmcm_rst_o;
  logic       rst_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic [7:0] retry_cnt_o;
  logic [1:0] state_o;

  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [43:0] exp_q[$];
  logic [11:0] prev;
  logic [11:0] cur;
  logic [43:0] ent;

  clk_rst_sequencer #(
    .MMCM_RST_CYCLES(4),
    .LOCK_TIMEOUT(100),
    .HOLD_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .locked_i(locked_i),
    .mmcm_rst_o(mmcm_rst_o),
    .rst_o(rst_o),
    .ready_o(ready_o),
    .lock_lost_o(lock_lost_o),
    .retry_cnt_o(retry_cnt_o),
    .state_o(state_o)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] ov(input logic m, input logic r, input logic l,
                                     input logic [7:0] rc);
    return {m, r, ~r, l, rc};
  endfunction

  task automatic push(input int c, input logic [11:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [1:0] want);
    total++;
    if (state_o !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d state got=%0d want=%0d", name, cyc, state_o, want);
    end
  endtask

  task automatic check_retry(input string name, input logic [7:0] want);
    total++;
    if (retry_cnt_o !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d retry got=%0d want=%0d", name, cyc, retry_cnt_o, want);
    end
  endtask

  // monitor: every change on the outputs must match the next expected event
  always @(negedge clk) begin
    cur = {mmcm_rst_o, rst_o, ready_o, lock_lost_o, retry_cnt_o};
    if (cur !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, cur);
      end else begin
        ent = exp_q.pop_front();
        if (ent[43:12] != 32'(cyc) || ent[11:0] !== cur) begin
          bad++;
          $display("FAIL output_event got cyc=%0d val=%h want cyc=%0d val=%h",
                   cyc, cur, ent[43:12], ent[11:0]);
        end
      end
    end
    prev = cur;
  end

  // stimulus
  initial begin
    int c;
    rst_i    = 1'b1;
    locked_i = 1'b0;
    push(1, ov(1, 1, 0, 8'd0));

    // power-up: reset for 3 cycles, lock 10 cycles after release
    wait_cyc(3);
    c = cyc; rst_i = 1'b0;
    push(c + 5, ov(0, 1, 0, 8'd0));
    wait_cyc(10);
    c = cyc; locked_i = 1'b1;
    push(c + 12, ov(0, 0, 0, 8'd0));
    wait_cyc(20);

    // lock loss in RUN, then relock
    c = cyc; locked_i = 1'b0;
    push(c + 4, ov(1, 1, 1, 8'd0));
    push(c + 8, ov(0, 1, 1, 8'd0));
    wait_cyc(10);
    c = cyc; locked_i = 1'b1;
    push(c + 12, ov(0, 0, 1, 8'd0));
    wait_cyc(20);

    // reset while in RUN clears lock_lost_o
    c = cyc; rst_i = 1'b1; locked_i = 1'b0;
    push(c + 1, ov(1, 1, 0, 8'd0));
    push(c + 6, ov(0, 1, 0, 8'd0));
    wait_cyc(1);
    rst_i = 1'b0;
    wait_cyc(6);

    // glitchy lock: 5 high, 1 low, then high
    c = cyc; locked_i = 1'b1;
    push(c + 18, ov(0, 0, 0, 8'd0));
    wait_cyc(5);
    locked_i = 1'b0;
    wait_cyc(1);
    locked_i = 1'b1;
    wait_cyc(1);
    check_state("glitch_hold", S_HOLD);
    wait_cyc(1);
    check_state("glitch_back_to_wait", S_WAIT);
    check_retry("glitch_no_retry", 8'd0);
    wait_cyc(20);

    // lock loss, relock, then reset while in HOLD
    c = cyc; locked_i = 1'b0;
    push(c + 4, ov(1, 1, 1, 8'd0));
    push(c + 8, ov(0, 1, 1, 8'd0));
    wait_cyc(10);
    locked_i = 1'b1;
    wait_cyc(4);
    check_state("hold_before_reset", S_HOLD);
    rst_i = 1'b1; locked_i = 1'b0;
    push(c + 15, ov(1, 1, 0, 8'd0));
    push(c + 20, ov(0, 1, 0, 8'd0));
    wait_cyc(1);
    rst_i = 1'b0;
    wait_cyc(5);

`ifdef CLK_RST_SEQ_RETRY_EN
    // no lock: re-pulse every 104 cycles, retry count saturating at 255
    for (int i = 0; i < 300; i++) begin
      push(c + 120 + 104 * i, ov(1, 1, 0, (i + 1 > 255) ? 8'd255 : 8'(i + 1)));
      push(c + 124 + 104 * i, ov(0, 1, 0, (i + 1 > 255) ? 8'd255 : 8'(i + 1)));
    end
    while (cyc < c + 120 + 104 * 299 + 10) @(negedge clk);
    check_retry("retry_saturated", 8'd255);
`else
    // no lock for 1000 cycles: no retry, then a late lock releases normally
    wait_cyc(1000);
    check_state("wait_forever", S_WAIT);
    check_retry("retry_tied_zero", 8'd0);
    c = cyc; locked_i = 1'b1;
    push(c + 12, ov(0, 0, 0, 8'd0));
    wait_cyc(14);
`endif

    // drain, then confirm nothing expected was missed
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      ent = exp_q[0];
      $display("FAIL missing_events left=%0d next want cyc=%0d val=%h",
               exp_q.size(), ent[43:12], ent[11:0]);
    end
    wait_cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
